branch_predictor: RTL and testbench

- Parametrised direction and target predictor that feeds the fetch-stage next-PC mux.
- Replaces the single-bit guess-taken input with three structures:
  - a direct-mapped branch target buffer (BTB);
  - per-entry saturating counters;
  - a return address stack (RAS).
- Fetch looks it up combinationally every cycle. Decode trains it when branches and jumps resolve. Exceptions and eret flush its speculative RAS state.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_ras.sv | 53 +++++
 rtl/branch_predictor.sv | 140 ++++++++++++++
 tb/tb_branch_predictor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the branch predictor.
//   bp_type_e   - control-transfer class recorded in each BTB entry
//   bp_entry_t  - one BTB entry; tag/cnt are sized for the largest
//                 supported TAG_W/CNT_W, and the predictor uses the low bits
//   BP_RESET_VEC- MIPS reset vector (first fetch PC after reset)
package bp_pkg;

    typedef enum logic [1:0] {
        BP_COND = 2'd0,
        BP_JUMP = 2'd1,
        BP_CALL = 2'd2,
        BP_RET  = 2'd3
    } bp_type_e;

    localparam int BP_TAG_MAX = 30;
    localparam int BP_CNT_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_MAX-1:0] tag;     // zero-extended from TAG_W bits
        logic [29:0]           target;  // pc[31:2]
        bp_type_e              btype;
        logic [BP_CNT_MAX-1:0] cnt;     // zero-extended from CNT_W bits
    } bp_entry_t;

    localparam logic [31:0] BP_RESET_VEC = 32'hBFC0_0000;

endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return address stack.
//   clk, rst  - clock, async active-high reset
//   push      - write push_addr at ptr, advance ptr (overwrites oldest when full)
//   pop       - retreat ptr; ignored when empty
//   flush     - empty the stack; wins over push/pop
//   top       - entry[ptr-1]
//   empty     - count == 0
module bp_ras
    import bp_pkg::*;
#(
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    input  logic        flush,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [31:0]      r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_top_idx;

    assign w_top_idx = r_ptr - PTR_W'(1);
    assign top       = r_stack[w_top_idx];
    assign empty     = (r_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) r_stack[i] <= '0;
        end else if (flush) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_stack[r_ptr] <= push_addr;
            r_ptr          <= r_ptr + PTR_W'(1);
            if (r_count != FULL) r_count <= r_count + 1'b1;
        end else if (pop && !empty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + saturating counters + RAS feeding the fetch next-PC mux.
//   clk, rst        - clock, async active-high reset
//   f_pc            - fetch PC looked up combinationally
//   pred_taken      - redirect predicted for f_pc
//   pred_target     - predicted next PC (f_pc+4 when not taken)
//   upd_*           - branch/jump resolution from decode, applied on the rising edge
//   flush           - exception/eret, empties the RAS (BTB kept)
//   mispred_cnt     - saturating count of resolved mispredicts
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int TAG_W     = 12,
    parameter int CNT_W     = 2,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] f_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  bp_type_e    upd_type,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        flush,
    output logic [31:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [BP_CNT_MAX-1:0] CNT_MAX = BP_CNT_MAX'((1 << CNT_W) - 1);
    localparam logic [BP_CNT_MAX-1:0] CNT_WT  = BP_CNT_MAX'(1 << (CNT_W - 1));
    localparam logic [BP_CNT_MAX-1:0] CNT_WNT = CNT_WT - 1'b1;

    bp_entry_t   r_btb [ENTRIES];
    logic [31:0] r_mispred;

    logic [IDX_W-1:0] w_fidx, w_uidx;
    logic [TAG_W-1:0] w_ftag, w_utag;
    logic             w_fhit, w_uhit, w_utaken, w_uwe;
    bp_entry_t        w_uent, w_unext;
    logic [31:0]      w_ras_top;
    logic             w_ras_empty;
    logic [1:0]       w_unused_tgt;

    assign w_unused_tgt = upd_target[1:0];

    assign w_fidx = f_pc[IDX_W+1:2];
    assign w_ftag = f_pc[IDX_W+2 +: TAG_W];
    assign w_uidx = upd_pc[IDX_W+1:2];
    assign w_utag = upd_pc[IDX_W+2 +: TAG_W];

    assign w_fhit = r_btb[w_fidx].valid && (r_btb[w_fidx].tag == BP_TAG_MAX'(w_ftag));

    // Lookup: pre-update contents only, no bypass from a same-cycle update.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = f_pc + 32'd4;
        if (w_fhit) begin
            unique case (r_btb[w_fidx].btype)
                BP_COND: begin
                    if (r_btb[w_fidx].cnt[CNT_W-1]) begin
                        pred_taken  = 1'b1;
                        pred_target = {r_btb[w_fidx].target, 2'b00};
                    end
                end
                BP_JUMP, BP_CALL: begin
                    pred_taken  = 1'b1;
                    pred_target = {r_btb[w_fidx].target, 2'b00};
                end
                BP_RET: begin
                    if (!w_ras_empty) begin
                        pred_taken  = 1'b1;
                        pred_target = w_ras_top;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next contents of the entry addressed by the update.
    always_comb begin
        w_uent   = r_btb[w_uidx];
        w_uhit   = w_uent.valid && (w_uent.tag == BP_TAG_MAX'(w_utag));
        w_utaken = (upd_type != BP_COND) || upd_taken;
        w_unext  = w_uent;
        w_uwe    = 1'b0;
        if (w_uhit) begin
            w_uwe = 1'b1;
            if (upd_type == BP_COND) begin
                if (upd_taken) begin
                    if (w_uent.cnt != CNT_MAX) w_unext.cnt = w_uent.cnt + 1'b1;
                    w_unext.target = upd_target[31:2];
                end else if (w_uent.cnt != '0) begin
                    w_unext.cnt = w_uent.cnt - 1'b1;
                end
            end else begin
                w_unext.target = upd_target[31:2];
                w_unext.btype  = upd_type;
            end
        end else if (w_utaken) begin
            w_uwe   = 1'b1;
            w_unext = '{valid: 1'b1, tag: BP_TAG_MAX'(w_utag), target: upd_target[31:2],
                        btype: upd_type, cnt: CNT_WT};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, btype: BP_COND, cnt: CNT_WNT};
        end else if (upd_valid && w_uwe) begin
            r_btb[w_uidx] <= w_unext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mispred <= '0;
        else if (upd_valid && upd_mispredict && (r_mispred != '1))
            r_mispred <= r_mispred + 32'd1;
    end

    assign mispred_cnt = r_mispred;

    bp_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (upd_valid && (upd_type == BP_CALL)),
        .pop       (upd_valid && (upd_type == BP_RET)),
        .push_addr (upd_pc + 32'd8),
        .flush     (flush),
        .top       (w_ras_top),
        .empty     (w_ras_empty)
    );

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    import bp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] f_pc = BP_RESET_VEC;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    bp_type_e    upd_type = BP_COND;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] mispred_cnt;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64), .TAG_W(12), .CNT_W(2), .RAS_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .f_pc(f_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush(flush),
        .mispred_cnt(mispred_cnt)
    );

    // kind 0: a[0]=expected pred_taken, b=expected pred_target; kind 1: a=expected mispred_cnt
    typedef struct packed {
        logic        kind;
        logic [31:0] a;
        logic [31:0] b;
    } chk_t;

    chk_t  q[$];
    string nq[$];
    logic  lk_v = 1'b0;
    int    n_tests = 0;
    int    n_fail  = 0;

    // Monitor: drains every expectation queued for the current cycle.
    always @(negedge clk) begin : mon
        chk_t  c;
        string nm;
        if (lk_v) begin
            while (q.size() > 0) begin
                c  = q.pop_front();
                nm = nq.pop_front();
                n_tests++;
                if (c.kind == 1'b0) begin
                    if (pred_taken !== c.a[0] || pred_target !== c.b) begin
                        n_fail++;
                        $display("FAIL %s: got taken=%0b target=%h, want taken=%0b target=%h",
                                 nm, pred_taken, pred_target, c.a[0], c.b);
                    end
                end else if (mispred_cnt !== c.a) begin
                    n_fail++;
                    $display("FAIL %s: got mispred_cnt=%0d, want %0d", nm, mispred_cnt, c.a);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lk_v = 1'b0;
        upd_valid = 1'b0;
        upd_mispredict = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drv(input logic [31:0] pc, input bp_type_e t, input logic tk,
                       input logic [31:0] tgt, input logic mp);
        upd_pc = pc; upd_type = t; upd_taken = tk; upd_target = tgt;
        upd_mispredict = mp; upd_valid = 1'b1;
    endtask

    task automatic ep(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input string nm);
        chk_t c;
        f_pc = pc;
        c.kind = 1'b0; c.a = {31'b0, t}; c.b = tgt;
        q.push_back(c); nq.push_back(nm);
        lk_v = 1'b1;
    endtask

    task automatic em(input logic [31:0] v, input string nm);
        chk_t c;
        c.kind = 1'b1; c.a = v; c.b = '0;
        q.push_back(c); nq.push_back(nm);
        lk_v = 1'b1;
    endtask

    localparam logic [31:0] A = 32'hBFC0_0100;
    localparam logic [31:0] S = 32'h0000_2048;

    initial begin
        @(posedge clk); #1;
        // reset
        ep(BP_RESET_VEC, 1'b0, 32'hBFC0_0004, "rst_lookup"); em(0, "rst_mcnt"); tick();
        rst = 1'b0;
        ep(BP_RESET_VEC, 1'b0, 32'hBFC0_0004, "post_rst_lookup"); tick();

        // allocation + counter saturation
        drv(A, BP_COND, 1'b1, 32'hBFC0_0200, 1'b0); ep(A, 1'b0, A + 4, "a_pre_alloc"); tick();
        ep(A, 1'b1, 32'hBFC0_0200, "a_alloc"); tick();
        drv(A, BP_COND, 1'b0, 32'hBFC0_0200, 1'b1); tick();
        drv(A, BP_COND, 1'b0, 32'hBFC0_0200, 1'b0); tick();
        ep(A, 1'b0, 32'hBFC0_0104, "a_nt2"); tick();
        repeat (3) begin drv(A, BP_COND, 1'b0, 32'hBFC0_0200, 1'b0); tick(); end
        drv(A, BP_COND, 1'b1, 32'hBFC0_0200, 1'b0); tick();
        ep(A, 1'b0, 32'hBFC0_0104, "a_sat_lo"); tick();
        drv(A, BP_COND, 1'b1, 32'hBFC0_0200, 1'b0); tick();
        ep(A, 1'b1, 32'hBFC0_0200, "a_retaken"); em(1, "mcnt_1"); tick();
        repeat (3) begin drv(A, BP_COND, 1'b1, 32'hBFC0_0200, 1'b0); tick(); end
        drv(A, BP_COND, 1'b0, 32'hBFC0_0200, 1'b0); tick();
        ep(A, 1'b1, 32'hBFC0_0200, "a_sat_hi"); tick();
        drv(A, BP_COND, 1'b0, 32'hBFC0_0200, 1'b0); tick();
        ep(A, 1'b0, 32'hBFC0_0104, "a_sat_hi_nt"); tick();

        // aliasing and not-taken miss
        drv(32'h0040_0010, BP_COND, 1'b1, 32'h0040_0800, 1'b0); tick();
        ep(32'h0040_1010, 1'b0, 32'h0040_1014, "alias_miss"); tick();
        ep(32'h0040_0010, 1'b1, 32'h0040_0800, "alias_hit"); tick();
        drv(32'h0040_0024, BP_COND, 1'b0, 32'h0040_0900, 1'b0); tick();
        ep(32'h0040_0024, 1'b0, 32'h0040_0028, "nt_no_alloc"); tick();

        // RAS basic
        drv(32'h504, BP_RET, 1'b1, 32'h0, 1'b0); tick();
        ep(32'h504, 1'b0, 32'h508, "ret_empty"); tick();
        drv(32'h100, BP_CALL, 1'b1, 32'h8000, 1'b0); tick();
        drv(32'h200, BP_CALL, 1'b1, 32'h8000, 1'b0); tick();
        drv(32'h300, BP_CALL, 1'b1, 32'h8000, 1'b0); tick();
        ep(32'h504, 1'b1, 32'h308, "ras_top3"); tick();
        drv(32'h504, BP_RET, 1'b1, 32'h308, 1'b0); tick();
        ep(32'h504, 1'b1, 32'h208, "ras_pop1"); tick();
        drv(32'h504, BP_RET, 1'b1, 32'h208, 1'b0); tick();
        ep(32'h504, 1'b1, 32'h108, "ras_pop2"); tick();
        drv(32'h504, BP_RET, 1'b1, 32'h108, 1'b0); tick();
        ep(32'h504, 1'b0, 32'h508, "ras_pop3_empty"); tick();
        ep(32'h300, 1'b1, 32'h8000, "call_btb"); tick();

        // RAS overflow: 9 pushes into depth 8, then 8 pops
        for (int k = 1; k <= 9; k++) begin
            drv(32'(k) << 12, BP_CALL, 1'b1, 32'h8000, 1'b0); tick();
        end
        for (int k = 9; k >= 2; k--) begin
            ep(32'h504, 1'b1, (32'(k) << 12) + 32'd8, $sformatf("ovf_top_%0d", k));
            drv(32'h504, BP_RET, 1'b1, 32'h0, 1'b0); tick();
        end
        ep(32'h504, 1'b0, 32'h508, "ovf_empty"); tick();

        // flush beats a simultaneous push; underflow is a no-op
        drv(32'h100, BP_CALL, 1'b1, 32'h8000, 1'b0); tick();
        drv(32'h200, BP_CALL, 1'b1, 32'h8000, 1'b0); tick();
        drv(32'h300, BP_CALL, 1'b1, 32'h8000, 1'b1); flush = 1'b1; tick();
        ep(32'h504, 1'b0, 32'h508, "flush_empty"); em(2, "mcnt_flush"); tick();
        drv(32'h504, BP_RET, 1'b1, 32'h0, 1'b0); tick();
        ep(32'h504, 1'b0, 32'h508, "underflow"); tick();
        ep(32'h300, 1'b1, 32'h8000, "btb_survive"); tick();
        drv(32'h700, BP_CALL, 1'b1, 32'h8000, 1'b0); tick();
        ep(32'h504, 1'b1, 32'h708, "push_after_uf"); tick();

        // same-cycle lookup/update: no bypass
        drv(S, BP_JUMP, 1'b1, 32'h3000, 1'b0); ep(S, 1'b0, S + 4, "same_cyc_old"); tick();
        ep(S, 1'b1, 32'h3000, "same_cyc_new"); tick();

        // upd_valid=0 with other inputs active changes nothing
        upd_pc = S; upd_type = BP_COND; upd_taken = 1'b0; upd_target = 32'h0;
        upd_mispredict = 1'b1; tick();
        ep(S, 1'b1, 32'h3000, "no_upd"); em(2, "mcnt_noupd"); tick();

        // asynchronous reset mid-update, checked before the next edge
        drv(S, BP_COND, 1'b0, 32'h0, 1'b1); rst = 1'b1;
        ep(S, 1'b0, S + 4, "async_rst"); em(0, "async_rst_mcnt"); tick();
        rst = 1'b0;
        ep(S, 1'b0, S + 4, "rst_discard"); em(0, "rst_discard_mcnt"); tick();

        repeat (3) begin drv(S, BP_JUMP, 1'b1, 32'h3000, 1'b1); tick(); end
        ep(S, 1'b1, 32'h3000, "jump_after_rst"); em(3, "mcnt_3"); tick();

        repeat (2) tick();
        while (q.size() > 0) begin
            void'(q.pop_front());
            $display("FAIL unchecked_%s: got no sample, want one", nq.pop_front());
            n_tests++;
            n_fail++;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
